speed_window_ctrl: RTL and testbench



---
 rtl/speed_window_ctrl_if.sv | 24 ++
 rtl/speed_window_ctrl.sv | 165 ++++++++++++++++
 tb/tb_speed_window_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/speed_window_ctrl_if.sv
// Signal bundle between speed_window_ctrl, the detector pin, the BCD pulse counter
// and the speed display/control logic.
interface speed_window_ctrl_if;
  logic        start;
  logic        continuous;
  logic        detector;
  logic [15:0] det_counter;
  logic        det_gated;
  logic        cnt_nCR;
  logic [15:0] speed_bcd;
  logic        valid;
  logic        busy;
  logic        ovf;

  modport slave (
    input  start, continuous, detector, det_counter,
    output det_gated, cnt_nCR, speed_bcd, valid, busy, ovf
  );

  modport master (
    output start, continuous, detector, det_counter,
    input  det_gated, cnt_nCR, speed_bcd, valid, busy, ovf
  );
endinterface

// File: rtl/speed_window_ctrl.sv
// Measurement-window controller: clears the BCD pulse counter, gates the synchronised
// detector into it for a fixed window and latches the count. Optional macro
// SPEED_WINDOW_OVF_EN adds a shadow pulse counter that saturates the sample at 9999.
module speed_window_ctrl #(
  parameter int unsigned WINDOW_CYCLES = 50000000,
  parameter int unsigned CLR_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input logic                clk,
  input logic                CR,
  speed_window_ctrl_if.slave sw
);

  localparam int unsigned MAX_A = (WINDOW_CYCLES > CLR_CYCLES) ? WINDOW_CYCLES : CLR_CYCLES;
  localparam int unsigned MAX_D = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_D + 1);
  localparam int unsigned BCD_W = 16;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_LATCH} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_last;
  logic [1:0]         r_sync;
  logic               w_det_s;
  logic               r_armed;
  logic               w_armed;
  logic               r_det_gated;
  logic               w_det_gated;
  logic               r_cnt_nCR;
  logic               w_cnt_nCR;
  logic               r_busy;
  logic               w_busy;
  logic               r_valid;
  logic               w_valid;
  logic [BCD_W-1:0]   r_speed_bcd;
  logic [BCD_W-1:0]   w_speed_bcd;

`ifdef SPEED_WINDOW_OVF_EN
  localparam int unsigned OVF_W = 14;
  logic [OVF_W-1:0]   r_pulse_cnt;
  logic [OVF_W-1:0]   w_pulse_cnt;
  logic               r_ovf;
  logic               w_ovf;
  logic               w_sat;
  assign w_sat = (r_pulse_cnt > OVF_W'(9999));
`endif

  assign w_det_s = r_sync[1];
  assign w_last  = (r_cnt == '0);

  // State register and per-state cycle counter
  always_ff @(posedge clk) begin
    if (CR) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state; the cycle counter reloads whenever a state is entered
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE:   if (sw.start) w_state_nxt = S_CLEAR;
      S_CLEAR:  if (w_last) w_state_nxt = S_GATE;
      S_GATE:   if (w_last) w_state_nxt = S_SETTLE;
      S_SETTLE: if (w_last) w_state_nxt = S_LATCH;
      S_LATCH:  w_state_nxt = sw.continuous ? S_CLEAR : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        S_CLEAR:  w_cnt_nxt = CNT_W'(CLR_CYCLES - 1);
        S_GATE:   w_cnt_nxt = CNT_W'(WINDOW_CYCLES - 1);
        S_SETTLE: w_cnt_nxt = CNT_W'(SETTLE_CYCLES - 1);
        default:  w_cnt_nxt = '0;
      endcase
    end else if (!w_last) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  // Output values for the coming cycle; a detector already low at window open stays masked
  always_comb begin
    w_armed     = 1'b0;
    w_det_gated = 1'b1;
    w_cnt_nCR   = (w_state_nxt != S_CLEAR);
    w_busy      = (w_state_nxt != S_IDLE);
    w_valid     = (r_state == S_LATCH);
    w_speed_bcd = r_speed_bcd;
    if (w_state_nxt == S_GATE) begin
      w_armed     = ((r_state == S_GATE) && r_armed) || w_det_s;
      w_det_gated = w_det_s || !w_armed;
    end
    if (r_state == S_LATCH) begin
`ifdef SPEED_WINDOW_OVF_EN
      w_speed_bcd = w_sat ? BCD_W'(16'h9999) : sw.det_counter;
`else
      w_speed_bcd = sw.det_counter;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (CR) begin
      r_sync      <= 2'b11;
      r_armed     <= 1'b0;
      r_det_gated <= 1'b1;
      r_cnt_nCR   <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_speed_bcd <= '0;
    end else begin
      r_sync      <= {r_sync[0], sw.detector};
      r_armed     <= w_armed;
      r_det_gated <= w_det_gated;
      r_cnt_nCR   <= w_cnt_nCR;
      r_busy      <= w_busy;
      r_valid     <= w_valid;
      r_speed_bcd <= w_speed_bcd;
    end
  end

`ifdef SPEED_WINDOW_OVF_EN
  // Shadow binary count of gated falling edges, saturating at all-ones
  always_comb begin
    w_pulse_cnt = r_pulse_cnt;
    w_ovf       = r_ovf;
    if ((w_state_nxt == S_CLEAR) && (r_state != S_CLEAR)) begin
      w_pulse_cnt = '0;
    end else if ((w_state_nxt == S_GATE) && r_det_gated && !w_det_gated &&
                 (r_pulse_cnt != '1)) begin
      w_pulse_cnt = r_pulse_cnt + OVF_W'(1);
    end
    if (r_state == S_LATCH) w_ovf = w_sat;
  end

  always_ff @(posedge clk) begin
    if (CR) begin
      r_pulse_cnt <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_pulse_cnt <= w_pulse_cnt;
      r_ovf       <= w_ovf;
    end
  end

  assign sw.ovf = r_ovf;
`else
  assign sw.ovf = 1'b0;
`endif

  assign sw.det_gated = r_det_gated;
  assign sw.cnt_nCR   = r_cnt_nCR;
  assign sw.speed_bcd = r_speed_bcd;
  assign sw.valid     = r_valid;
  assign sw.busy      = r_busy;

endmodule

// File: tb/tb_speed_window_ctrl.sv
// Scoreboard bench for speed_window_ctrl: a short-window and a long-window instance,
// each driving a behavioural BCD pulse counter; expected samples come from a window model.
module tb_speed_window_ctrl;

  localparam int unsigned C  = 2;
  localparam int unsigned S  = 4;
  localparam int unsigned W1 = 100;
  localparam int unsigned W2 = 30000;

  typedef struct {
    int          due;
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  // Detector waveform: level pre before cycle sw, then hi-high/lo-low square wave
  typedef struct {
    int sw;
    int pre;
    int hi;
    int lo;
    int ph;
  } wave_t;

  logic  clk = 1'b0;
  logic  CR  = 1'b1;
  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;
  int    ca = 0;
  int    cb = 0;
  exp_t  sb_a[$];
  exp_t  sb_b[$];
  wave_t wa = '{sw: 0, pre: 1, hi: 5, lo: 5, ph: 0};
  wave_t wb = '{sw: 0, pre: 1, hi: 1, lo: 1, ph: 0};

  speed_window_ctrl_if a_if ();
  speed_window_ctrl_if b_if ();

  speed_window_ctrl #(.WINDOW_CYCLES(W1), .CLR_CYCLES(C), .SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .CR(CR), .sw(a_if)
  );
  speed_window_ctrl #(.WINDOW_CYCLES(W2), .CLR_CYCLES(C), .SETTLE_CYCLES(S)) u_long (
    .clk(clk), .CR(CR), .sw(b_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] to_bcd(input int v);
    int x;
    x = v % 10000;
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  function automatic bit wave(input wave_t w, input int n);
    if (n < w.sw) return bit'(w.pre);
    if (w.hi + w.lo == 0) return 1'b0;
    return ((n + w.ph) % (w.hi + w.lo)) < w.hi;
  endfunction

  // Falling edges the counter sees: detector delayed two cycles, masked until first seen high
  function automatic int model_count(input wave_t w, input int g0, input int win);
    bit armed, prev, g, s;
    int c;
    armed = 1'b0; prev = 1'b1; c = 0;
    for (int k = 0; k < win; k++) begin
      s = wave(w, g0 + k - 2);
      if (s) armed = 1'b1;
      g = armed ? s : 1'b1;
      if (prev && !g) c++;
      prev = g;
    end
    return c;
  endfunction

  function automatic exp_t make_exp(input wave_t w, input int g0, input int win, input int due);
    exp_t e;
    int   c;
    c = model_count(w, g0, win);
    e.due = due;
`ifdef SPEED_WINDOW_OVF_EN
    e.ovf = (c > 9999);
    e.bcd = e.ovf ? 16'h9999 : to_bcd(c);
`else
    e.ovf = 1'b0;
    e.bcd = to_bcd(c);
`endif
    return e;
  endfunction

  // Behavioural ripple BCD counters: advance on det_gated falling edge, clear on cnt_nCR low
  always @(negedge a_if.det_gated or negedge a_if.cnt_nCR)
    if (!a_if.cnt_nCR) ca <= 0; else ca <= ca + 1;
  always @(negedge b_if.det_gated or negedge b_if.cnt_nCR)
    if (!b_if.cnt_nCR) cb <= 0; else cb <= cb + 1;
  assign a_if.det_counter = to_bcd(ca);
  assign b_if.det_counter = to_bcd(cb);

  initial begin
    a_if.detector = 1'b1;
    b_if.detector = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      a_if.detector = wave(wa, cyc + 1);
      b_if.detector = wave(wb, cyc + 1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every valid strobe
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (a_if.valid) begin
        if (sb_a.size() == 0) chk("a_spurious_valid", 32'(a_if.valid), 32'd0);
        else begin
          e = sb_a.pop_front();
          chk("a_valid_cycle", 32'(cyc), 32'(e.due));
          chk("a_speed_bcd", 32'(a_if.speed_bcd), 32'(e.bcd));
          chk("a_ovf", 32'(a_if.ovf), 32'(e.ovf));
        end
      end else if (sb_a.size() > 0 && cyc > sb_a[0].due) begin
        e = sb_a.pop_front();
        chk("a_missing_valid", 32'(a_if.valid), 32'd1);
      end
      if (b_if.valid) begin
        if (sb_b.size() == 0) chk("b_spurious_valid", 32'(b_if.valid), 32'd0);
        else begin
          e = sb_b.pop_front();
          chk("b_valid_cycle", 32'(cyc), 32'(e.due));
          chk("b_speed_bcd", 32'(b_if.speed_bcd), 32'(e.bcd));
          chk("b_ovf", 32'(b_if.ovf), 32'(e.ovf));
        end
      end else if (sb_b.size() > 0 && cyc > sb_b[0].due) begin
        e = sb_b.pop_front();
        chk("b_missing_valid", 32'(b_if.valid), 32'd1);
      end
    end
  end

  task automatic issue(input bit sel, input int nsamp, output int t0);
    int   w;
    int   p;
    exp_t e;
    w  = sel ? int'(W2) : int'(W1);
    p  = int'(C + S + 1) + w;
    t0 = cyc + 1;
    for (int m = 0; m < nsamp; m++) begin
      e = make_exp(sel ? wb : wa, t0 + m * p + int'(C), w, t0 + (m + 1) * p);
      if (sel) sb_b.push_back(e); else sb_a.push_back(e);
    end
    if (sel) b_if.start = 1'b1; else a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    b_if.start = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    int budget;
    budget = 0;
    while ((sel ? sb_b.size() : sb_a.size()) > 0 && budget < 40000) begin
      @(negedge clk);
      budget++;
    end
    chk(sel ? "b_drain_timeout" : "a_drain_timeout", 32'(sel ? sb_b.size() : sb_a.size()), 32'd0);
    @(negedge clk);
    chk(sel ? "b_busy_after_sample" : "a_busy_after_sample",
        32'(sel ? b_if.busy : a_if.busy), 32'd0);
  endtask

  task automatic run_continuous(input int nsamp);
    int t0;
    int stop_at;
    a_if.continuous = 1'b1;
    issue(1'b0, nsamp, t0);
    repeat (30) @(negedge clk);
    a_if.continuous = 1'b0;
    repeat (20) @(negedge clk);
    a_if.continuous = 1'b1;
    stop_at = t0 + (nsamp - 1) * int'(C + W1 + S + 1);
    while (cyc < stop_at) @(negedge clk);
    a_if.continuous = 1'b0;
    wait_idle(1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    a_if.start = 1'b0; a_if.continuous = 1'b0;
    b_if.start = 1'b0; b_if.continuous = 1'b0;

    // Reset held for three cycles
    repeat (3) begin
      @(negedge clk);
      chk("rst_cnt_nCR", 32'(a_if.cnt_nCR), 32'd0);
      chk("rst_det_gated", 32'(a_if.det_gated), 32'd1);
      chk("rst_speed_bcd", 32'(a_if.speed_bcd), 32'd0);
      chk("rst_valid", 32'(a_if.valid), 32'd0);
      chk("rst_busy", 32'(a_if.busy), 32'd0);
      chk("rst_ovf", 32'(a_if.ovf), 32'd0);
    end
    CR = 1'b0;
    @(negedge clk);
    chk("idle_cnt_nCR", 32'(a_if.cnt_nCR), 32'd1);
    chk("idle_busy", 32'(a_if.busy), 32'd0);
    repeat (5) @(negedge clk);

    // Period-10 square wave, high at window open; start mid-window is ignored
    wa = '{sw: 0, pre: 1, hi: 5, lo: 5, ph: (10 - ((cyc + 1) % 10)) % 10};
    issue(1'b0, 1, t0);
    repeat (50) @(negedge clk);
    chk("busy_in_gate", 32'(a_if.busy), 32'd1);
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    wait_idle(1'b0);

    // Detector low at window open, then held high
    wa = '{sw: cyc + 20, pre: 0, hi: 1, lo: 0, ph: 0};
    issue(1'b0, 1, t0);
    wait_idle(1'b0);

    // Continuous mode with a period-4 wave, three samples
    wa = '{sw: 0, pre: 1, hi: 2, lo: 2, ph: 0};
    run_continuous(3);

    // Randomised single shots
    for (int r = 0; r < 6; r++) begin
      wa.hi  = int'($urandom_range(1, 6));
      wa.lo  = int'($urandom_range(1, 6));
      wa.ph  = int'($urandom_range(0, 11));
      wa.pre = int'($urandom_range(0, 1));
      wa.sw  = cyc + int'($urandom_range(0, 60));
      issue(1'b0, 1, t0);
      wait_idle(1'b0);
    end

    // Randomised continuous run
    wa = '{sw: 0, pre: 1, hi: int'($urandom_range(1, 4)), lo: int'($urandom_range(1, 4)),
           ph: int'($urandom_range(0, 7))};
    run_continuous(int'($urandom_range(2, 3)));

    // Reset at gate cycle 50 with a coincident start: abort, no sample
    wa = '{sw: 0, pre: 1, hi: 3, lo: 3, ph: 0};
    t0 = cyc + 1;
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    while (cyc < t0 + int'(C) + 49) @(negedge clk);
    CR = 1'b1;
    a_if.start = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(a_if.busy), 32'd0);
    chk("abort_cnt_nCR", 32'(a_if.cnt_nCR), 32'd0);
    chk("abort_speed_bcd", 32'(a_if.speed_bcd), 32'd0);
    chk("abort_det_gated", 32'(a_if.det_gated), 32'd1);
    @(negedge clk);
    chk("abort_cnt_nCR_held", 32'(a_if.cnt_nCR), 32'd0);
    CR = 1'b0;
    a_if.start = 1'b0;
    @(negedge clk);
    chk("abort_busy_after", 32'(a_if.busy), 32'd0);
    chk("abort_cnt_nCR_after", 32'(a_if.cnt_nCR), 32'd1);
    repeat (150) @(negedge clk);
    chk("abort_no_sample", 32'(a_if.speed_bcd), 32'd0);

    // Long window with a period-2 detector: beyond 9999 pulses
    wb = '{sw: 0, pre: 1, hi: 1, lo: 1, ph: 0};
    issue(1'b1, 1, t0);
    wait_idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
